// File: rtl/ride_dispatch_ctrl.sv
// Queue/ride sequencing controller: tracks waiting people, dispatches ride runs,
// and times the BOARD/RIDE phases. Optional macro AUTO_GO_EN enables automatic dispatch.
module ride_dispatch_ctrl #(
  parameter int unsigned CAP      = 20,
  parameter int unsigned SEAT     = 8,
  parameter int unsigned LOAD_CYC = 4,
  parameter int unsigned RIDE_CYC = 50000000,
  parameter int unsigned CNT_W    = 5
) (
  input  logic             CLOCK_50,
  input  logic             rst,
  input  logic [2:0]       add_p,
  input  logic             go_p,
  output logic [CNT_W-1:0] count,
  output logic [2:0]       runs,
  output logic [1:0]       phase,
  output logic             busy,
  output logic             ovf,
  output logic             rej
);

  localparam int unsigned TMR_MAX = (LOAD_CYC > RIDE_CYC) ? LOAD_CYC : RIDE_CYC;
  localparam int unsigned TMR_W   = (TMR_MAX > 2) ? $clog2(TMR_MAX) : 1;
  localparam int unsigned SUM_W   = CNT_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BOARD = 2'd1,
    RIDE  = 2'd2
  } phase_t;

  phase_t           state, state_n;
  logic [TMR_W-1:0] timer, timer_n;
  logic [CNT_W-1:0] count_n;
  logic             ovf_n, rej_n;
  logic             trig_c, dispatch_c;
  logic [SUM_W-1:0] post_c, group_c, sum_c;

  // Highest-value arrival bit wins; lower bits are discarded.
  always_comb begin
    group_c = '0;
    if (add_p[2])      group_c = SUM_W'(12);
    else if (add_p[1]) group_c = SUM_W'(8);
    else if (add_p[0]) group_c = SUM_W'(4);
  end

`ifdef AUTO_GO_EN
  assign trig_c = 1'b1;
`else
  assign trig_c = go_p;
`endif

  // Dispatch is resolved first; the arrival is then checked against the post-dispatch count.
  assign dispatch_c = (state == IDLE) && trig_c && (SUM_W'(count) >= SUM_W'(SEAT));
  assign post_c     = dispatch_c ? (SUM_W'(count) - SUM_W'(SEAT)) : SUM_W'(count);
  assign sum_c      = post_c + group_c;

  always_comb begin
    state_n = state;
    timer_n = timer;
    count_n = CNT_W'(post_c);
    ovf_n   = 1'b0;
    rej_n   = go_p && !dispatch_c;

    if (group_c != '0) begin
      if (sum_c <= SUM_W'(CAP)) count_n = CNT_W'(sum_c);
      else                      ovf_n   = 1'b1;
    end

    case (state)
      IDLE: begin
        if (dispatch_c) begin
          state_n = BOARD;
          timer_n = TMR_W'(LOAD_CYC - 1);
        end
      end
      BOARD: begin
        if (timer == '0) begin
          state_n = RIDE;
          timer_n = TMR_W'(RIDE_CYC - 1);
        end else begin
          timer_n = timer - TMR_W'(1);
        end
      end
      RIDE: begin
        if (timer == '0) state_n = IDLE;
        else             timer_n = timer - TMR_W'(1);
      end
      default: begin
        state_n = IDLE;
        timer_n = '0;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      state <= IDLE;
      timer <= '0;
      count <= '0;
      busy  <= 1'b0;
      ovf   <= 1'b0;
      rej   <= 1'b0;
    end else begin
      state <= state_n;
      timer <= timer_n;
      count <= count_n;
      busy  <= (state_n != IDLE);
      ovf   <= ovf_n;
      rej   <= rej_n;
    end
  end

  assign phase = state;
  assign runs  = 3'(count / CNT_W'(SEAT));

endmodule

// File: tb/tb_ride_dispatch_ctrl.sv
// Bench for ride_dispatch_ctrl: directed plan steps followed by random pulses,
// all checked each cycle against a phase/countdown reference model.
module tb_ride_dispatch_ctrl;

  localparam int CAP  = 20;
  localparam int SEAT = 8;
  localparam int LOAD = 4;
  localparam int RIDE = 10;
`ifdef AUTO_GO_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic       CLOCK_50;
  logic       rst;
  logic [2:0] add_p;
  logic       go_p;
  logic [4:0] count;
  logic [2:0] runs;
  logic [1:0] phase;
  logic       busy, ovf, rej;

  int checks   = 0;
  int failures = 0;

  int m_count, m_phase, m_left;
  bit m_ovf, m_rej;

  ride_dispatch_ctrl #(
    .CAP(CAP), .SEAT(SEAT), .LOAD_CYC(LOAD), .RIDE_CYC(RIDE), .CNT_W(5)
  ) dut (
    .CLOCK_50(CLOCK_50), .rst(rst), .add_p(add_p), .go_p(go_p),
    .count(count), .runs(runs), .phase(phase), .busy(busy), .ovf(ovf), .rej(rej)
  );

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: people count plus a "cycles left in this phase" countdown.
  task automatic model(input bit r, input logic [2:0] a, input bit g);
    bit disp;
    int cp, grp;
    if (r) begin
      m_count = 0; m_phase = 0; m_left = 0; m_ovf = 0; m_rej = 0;
      return;
    end
    disp  = (m_phase == 0) && (m_count >= SEAT) && (g || AUTO);
    m_rej = g && !disp;
    cp    = disp ? m_count - SEAT : m_count;
    grp   = a[2] ? 12 : a[1] ? 8 : a[0] ? 4 : 0;
    m_ovf = (grp != 0) && (cp + grp > CAP);
    m_count = (grp != 0 && cp + grp <= CAP) ? cp + grp : cp;
    if (disp) begin
      m_phase = 1; m_left = LOAD;
    end else if (m_phase != 0) begin
      m_left--;
      if (m_left == 0) begin
        if (m_phase == 1) begin m_phase = 2; m_left = RIDE; end
        else m_phase = 0;
      end
    end
  endtask

  task automatic step(input bit r, input logic [2:0] a, input bit g);
    rst = r; add_p = a; go_p = g;
    @(posedge CLOCK_50);
    model(r, a, g);
    #1;
    rst = 1'b0; add_p = 3'b000; go_p = 1'b0;
    chk("count", 32'(count), 32'(m_count));
    chk("runs",  32'(runs),  32'(m_count / SEAT));
    chk("phase", 32'(phase), 32'(m_phase));
    chk("busy",  32'(busy),  32'(m_phase != 0));
    chk("ovf",   32'(ovf),   32'(m_ovf));
    chk("rej",   32'(rej),   32'(m_rej));
  endtask

  initial begin
    rst = 1'b1; add_p = 3'b000; go_p = 1'b0;
    m_count = 0; m_phase = 0; m_left = 0; m_ovf = 0; m_rej = 0;

    // Plan 1: reset then +12
    step(1, 3'b000, 0);
    step(1, 3'b000, 0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_phase", 32'(phase), 32'd0);
    step(0, 3'b100, 0);
`ifndef AUTO_GO_EN
    chk("p1_count", 32'(count), 32'd12);
    chk("p1_runs",  32'(runs),  32'd1);
`endif
    // Plan 2: fill to CAP, then overflow
    step(0, 3'b010, 0);
    step(0, 3'b001, 0);
`ifndef AUTO_GO_EN
    chk("p2_count", 32'(count), 32'd20);
    chk("p2_ovf",   32'(ovf),   32'd1);
`endif
    step(0, 3'b000, 0);
    // Plan 3: dispatch, full BOARD+RIDE, go during RIDE
    step(0, 3'b000, 1);
    for (int i = 0; i < 18; i++) step(0, 3'b000, (i == 8));
    // Plan 4: reject with too few, then multi-bit arrival
    step(1, 3'b000, 0);
    step(0, 3'b001, 0);
    step(0, 3'b000, 1);
    step(0, 3'b111, 0);
    // Plan 5: dispatch and arrival in the same cycle
    step(1, 3'b000, 0);
    step(0, 3'b100, 0);
    step(0, 3'b010, 0);
    step(0, 3'b100, 1);
    step(0, 3'b010, 0);
    for (int i = 0; i < 16; i++) step(0, 3'b000, 0);
    step(0, 3'b010, 1);
    // Plan 6: reset in RIDE cycle 5, then auto/idle behaviour
    for (int i = 0; i < 8; i++) step(0, 3'b000, 0);
    step(1, 3'b000, 0);
    chk("p6_phase", 32'(phase), 32'd0);
    chk("p6_busy",  32'(busy),  32'd0);
    step(0, 3'b010, 0);
    step(0, 3'b000, 0);
    for (int i = 0; i < 16; i++) step(0, 3'b000, 0);

    // Random pulses
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 299) == 0),
           ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'b000,
           ($urandom_range(0, 5) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
